// File: rtl/octree_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : octree_cmd_queue
// Description : Command queue and sequencer for the octree engine. Accepts
//               SEARCH/ADD/DEL commands into a circular FIFO and issues them
//               one at a time on ctrl. Each issued command is held until the
//               matching done pulse arrives or the timeout expires.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               cmd_valid/op/ready   - command push handshake (op 0 illegal)
//               flush                - drop all queued, not-yet-issued commands
//               ctrl                 - registered op code to the control stage
//               search/add/del_done  - completion pulses
//               rsp_valid, rsp_op    - one-cycle completion report
//               busy, count          - activity and FIFO occupancy
//               ill_cmd              - pulse after an illegal op is accepted
//               err_timeout          - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module octree_cmd_queue #(
    parameter int CONTROL_WIDTH = 8,
    parameter int DEPTH         = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd_op,
    output logic                       cmd_ready,
    input  logic                       flush,
    output logic [CONTROL_WIDTH-1:0]   ctrl,
    input  logic                       search_done,
    input  logic                       add_done,
    input  logic                       del_done,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_op,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ill_cmd,
    output logic                       err_timeout
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TO_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [1:0]           r_op;
    logic [c_TO_W-1:0]    r_timer;

    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_match;
    logic w_timeout;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign cmd_ready = !w_full;
    assign w_accept  = cmd_valid && cmd_ready;
    // Illegal ops complete the handshake but never occupy a slot; a push
    // coinciding with flush is dropped along with the queue contents.
    assign w_push    = w_accept && (cmd_op != 2'd0) && !flush;
    // Pop only from what was stored before this edge, so a push into an
    // empty FIFO is never bypassed straight to the FSM.
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !flush;
    assign w_match   = ((r_op == 2'd1) && search_done) ||
                       ((r_op == 2'd2) && add_done)    ||
                       ((r_op == 2'd3) && del_done);
    assign w_timeout = (r_timer == c_TO_W'(TIMEOUT - 1));

    assign count = r_count;
    assign busy  = (r_state != S_IDLE) || (r_count != '0);

    // Circular command FIFO; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= cmd_op;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Issue sequencer. ctrl and the response are registered so they are
    // glitch-free toward the control stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 2'd0;
            r_timer     <= '0;
            ctrl        <= '0;
            rsp_valid   <= 1'b0;
            rsp_op      <= 2'd0;
            ill_cmd     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ill_cmd   <= w_accept && (cmd_op == 2'd0);
            ctrl      <= '0;
            rsp_valid <= 1'b0;
            rsp_op    <= 2'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op    <= r_mem[r_rd_ptr];
                        ctrl    <= CONTROL_WIDTH'(r_mem[r_rd_ptr]);
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A matching done on the last allowed cycle still counts.
                    if (w_match) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= r_op;
                        r_state   <= S_IDLE;
                    end else if (w_timeout) begin
                        err_timeout <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_octree_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_octree_cmd_queue
// Description : Self-checking bench for octree_cmd_queue. Expected issue
//               order and expected responses are queued as stimulus is
//               driven and compared as the DUT produces ctrl / rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_octree_cmd_queue;

    localparam int CW      = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic [1:0]              cmd_op;
    logic                    cmd_ready;
    logic                    flush;
    logic [CW-1:0]           ctrl;
    logic                    search_done;
    logic                    add_done;
    logic                    del_done;
    logic                    rsp_valid;
    logic [1:0]              rsp_op;
    logic                    busy;
    logic [$clog2(DEPTH):0]  count;
    logic                    ill_cmd;
    logic                    err_timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc = -100;

    logic [1:0] exp_ctrl [$];
    logic [1:0] exp_rsp  [$];

    octree_cmd_queue #(
        .CONTROL_WIDTH (CW),
        .DEPTH         (DEPTH),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .flush       (flush),
        .ctrl        (ctrl),
        .search_done (search_done),
        .add_done    (add_done),
        .del_done    (del_done),
        .rsp_valid   (rsp_valid),
        .rsp_op      (rsp_op),
        .busy        (busy),
        .count       (count),
        .ill_cmd     (ill_cmd),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input bit store);
        cmd_valid = 1'b1;
        cmd_op    = op;
        if (store) exp_ctrl.push_back(op);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
    endtask

    task automatic do_done(input logic [1:0] op);
        case (op)
            2'd1:    search_done = 1'b1;
            2'd2:    add_done    = 1'b1;
            default: del_done    = 1'b1;
        endcase
        exp_rsp.push_back(op);
        tick();
        search_done = 1'b0;
        add_done    = 1'b0;
        del_done    = 1'b0;
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_op", {30'd0, rsp_op}, {30'd0, op});
    endtask

    task automatic wait_issue();
        for (int i = 0; i < 40 && ctrl == '0; i++) tick();
        check("issued", {31'd0, ctrl != '0}, 32'd1);
    endtask

    // Scoreboard: every issue and every response is matched against the
    // queues filled by the stimulus.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (ctrl != '0) begin
                if (exp_ctrl.size() == 0) check("ctrl_unexpected", 32'(ctrl), 32'd0);
                else check("ctrl_order", 32'(ctrl), 32'(exp_ctrl.pop_front()));
                check("issue_gap", {31'd0, (cyc - done_cyc) >= 2}, 32'd1);
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                else check("rsp_order", {30'd0, rsp_op}, 32'(exp_rsp.pop_front()));
            end
            if (search_done || add_done || del_done) done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; flush = 1'b0;
        search_done = 1'b0; add_done = 1'b0; del_done = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_op", {30'd0, rsp_op}, 32'd0);
        check("rst_ill", {31'd0, ill_cmd}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Single SEARCH with exact cycle timing (push in cycle 0).
        push(2'd1, 1'b1);
        check("a_count", 32'(count), 32'd1);
        check("a_ctrl_c1", 32'(ctrl), 32'd0);
        check("a_busy", {31'd0, busy}, 32'd1);
        tick();
        check("a_ctrl_c2", 32'(ctrl), 32'd1);
        tick();
        check("a_ctrl_c3", 32'(ctrl), 32'd0);
        tick();
        tick();
        do_done(2'd1);
        check("a_busy_c6", {31'd0, busy}, 32'd0);
        tick();
        check("a_rsp_c7", {31'd0, rsp_valid}, 32'd0);

        // ADD, DEL, SEARCH back to back; stray add_done during DEL wait.
        push(2'd2, 1'b1);
        push(2'd3, 1'b1);
        push(2'd1, 1'b1);
        check("b_count", 32'(count), 32'd2);
        tick();
        do_done(2'd2);
        wait_issue();
        tick();
        tick();
        add_done = 1'b1;
        tick();
        add_done = 1'b0;
        check("b_ign_add", {31'd0, rsp_valid}, 32'd0);
        do_done(2'd3);
        wait_issue();
        tick();
        do_done(2'd1);
        tick();

        // Fill the FIFO behind a stalled SEARCH; the fifth push is refused.
        push(2'd1, 1'b1);
        wait_issue();
        push(2'd2, 1'b1);
        push(2'd3, 1'b1);
        push(2'd1, 1'b1);
        push(2'd2, 1'b1);
        check("c_count_full", 32'(count), 32'd4);
        check("c_ready_full", {31'd0, cmd_ready}, 32'd0);
        push(2'd3, 1'b0);
        check("c_count_refused", 32'(count), 32'd4);
        do_done(2'd1);
        begin
            logic [1:0] ops [4];
            ops[0] = 2'd2; ops[1] = 2'd3; ops[2] = 2'd1; ops[3] = 2'd2;
            for (int i = 0; i < 4; i++) begin
                wait_issue();
                if (i == 0) check("c_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
                tick();
                do_done(ops[i]);
            end
        end
        tick();

        // Illegal op: handshake completes, nothing stored.
        push(2'd0, 1'b0);
        check("e_ill_pulse", {31'd0, ill_cmd}, 32'd1);
        check("e_count", 32'(count), 32'd0);
        check("e_ctrl", 32'(ctrl), 32'd0);
        tick();
        check("e_ill_clear", {31'd0, ill_cmd}, 32'd0);
        check("e_ctrl2", 32'(ctrl), 32'd0);
        check("e_busy", {31'd0, busy}, 32'd0);

        // Matching done on the final timeout cycle wins.
        push(2'd1, 1'b1);
        wait_issue();
        repeat (TIMEOUT) tick();
        do_done(2'd1);
        check("d_err_not_set", {31'd0, err_timeout}, 32'd0);
        tick();

        // Withheld done: timeout after TIMEOUT cycles, next op still issues.
        push(2'd3, 1'b1);
        push(2'd2, 1'b1);
        wait_issue();
        repeat (TIMEOUT) tick();
        check("t_err_before", {31'd0, err_timeout}, 32'd0);
        tick();
        check("t_err_set", {31'd0, err_timeout}, 32'd1);
        check("t_no_rsp", {31'd0, rsp_valid}, 32'd0);
        wait_issue();
        tick();
        do_done(2'd2);
        check("t_err_sticky", {31'd0, err_timeout}, 32'd1);
        tick();

        // Flush with three queued and one in flight; push during flush dropped.
        push(2'd1, 1'b1);
        wait_issue();
        push(2'd2, 1'b0);
        push(2'd3, 1'b0);
        push(2'd1, 1'b0);
        check("f_count_pre", 32'(count), 32'd3);
        flush = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2;
        tick();
        flush = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
        check("f_count_post", 32'(count), 32'd0);
        check("f_busy_inflight", {31'd0, busy}, 32'd1);
        do_done(2'd1);
        check("f_busy_done", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("f_count_idle", 32'(count), 32'd0);

        // Reset during WAIT_DONE abandons the op silently.
        push(2'd2, 1'b1);
        wait_issue();
        tick();
        rst = 1'b1;
        tick();
        check("r_ctrl", 32'(ctrl), 32'd0);
        check("r_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("r_rsp_op", {30'd0, rsp_op}, 32'd0);
        check("r_ill", {31'd0, ill_cmd}, 32'd0);
        check("r_err", {31'd0, err_timeout}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd0);
        check("r_count", 32'(count), 32'd0);
        check("r_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        repeat (5) tick();
        check("r_quiet_rsp", {31'd0, rsp_valid}, 32'd0);
        check("r_quiet_busy", {31'd0, busy}, 32'd0);

        check("sb_ctrl_empty", 32'(exp_ctrl.size()), 32'd0);
        check("sb_rsp_empty", 32'(exp_rsp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
